// File: rtl/store_pkg.sv
// store_pkg
// Shared definitions for the store buffer: RISC-V store funct3 encodings and
// the layout of one queued store entry.
package store_pkg;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  // waddr is sized for a full 32-bit byte address space; the store buffer
  // zero-fills the bits above its own ADDR_W so whole-field compares work.
  typedef struct packed {
    logic [29:0] waddr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } sb_entry_t;

endpackage

// File: rtl/store_lane_encoder.sv
// store_lane_encoder
// Combinational conversion of a store (funct3, low address bits, rs2 data)
// into byte-lane strobes and lane-replicated write data.
// Ports:
//   funct3_i - store width encoding (SB/SH/SW)
//   addr_i   - st_addr[1:0], byte offset inside the word
//   data_i   - rs2 value
//   strb_o   - byte-lane enables, bit i covers data bits [8i+7:8i]
//   wdata_o  - write data replicated across the lanes
//   err_o    - store is misaligned or funct3 is not a legal store
module store_lane_encoder (
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] data_i,
  output logic [3:0]  strb_o,
  output logic [31:0] wdata_o,
  output logic        err_o
);
  import store_pkg::*;

  always_comb begin
    strb_o  = 4'b0000;
    wdata_o = 32'h0;
    err_o   = 1'b0;
    case (funct3_i)
      F3_SB: begin
        strb_o  = 4'b0001 << addr_i;
        wdata_o = {4{data_i[7:0]}};
      end
      F3_SH: begin
        strb_o  = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{data_i[15:0]}};
        err_o   = addr_i[0];
      end
      F3_SW: begin
        strb_o  = 4'b1111;
        wdata_o = data_i;
        err_o   = (addr_i != 2'b00);
      end
      default: begin
        err_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// store_buffer
// In-order store queue between the MEM stage and the data memory write port.
// Stores are encoded into word address / strobe / replicated data, queued,
// and drained one per cycle whenever a load does not own the memory port.
// Loads whose word matches any queued store raise ld_hit.
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   st_valid/st_ready    - store handshake from the MEM stage
//   st_addr/st_data/st_funct3 - store byte address, rs2 value, width
//   mem_busy             - a load owns the memory port this cycle
//   mem_we/mem_addr/mem_strb/mem_wdata - data memory write port
//   ld_valid/ld_addr/ld_hit - load-vs-pending-store hazard check
//   misalign_err         - one-cycle pulse after a rejected store
//   empty/count          - queue occupancy
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [31:0]              st_addr,
  input  logic [DATA_W-1:0]        st_data,
  input  logic [2:0]               st_funct3,
  input  logic                     mem_busy,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [3:0]               mem_strb,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     ld_valid,
  input  logic [31:0]              ld_addr,
  output logic                     ld_hit,
  output logic                     misalign_err,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  import store_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] headPtr_q, headPtr_d;
  logic [PW-1:0] tailPtr_q, tailPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          misalignErr_q, misalignErr_d;
  sb_entry_t     fifo_q [DEPTH];

  logic [3:0]    encStrb;
  logic [31:0]   encWdata;
  logic          encErr;
  logic          accept;
  logic          push;
  logic          pop;
  sb_entry_t     newEntry;
  sb_entry_t     headEntry;
  logic [29:0]   ldWord;
  logic          anyHit;
  logic [PW-1:0] offset;

  // Address bits outside the modelled data memory are intentionally dropped.
  logic unusedAddrBits;
  assign unusedAddrBits = ^{st_addr[31:ADDR_W], ld_addr[31:ADDR_W], ld_addr[1:0]};

  store_lane_encoder u_encoder (
    .funct3_i (st_funct3),
    .addr_i   (st_addr[1:0]),
    .data_i   (st_data),
    .strb_o   (encStrb),
    .wdata_o  (encWdata),
    .err_o    (encErr)
  );

  // st_ready ignores a same-cycle drain so it never depends on mem_busy.
  assign empty    = (count_q == '0);
  assign st_ready = (count_q < CW'(DEPTH));
  assign accept   = st_valid && st_ready;
  assign push     = accept && !encErr;

  // No write may leave the buffer in a reset cycle.
  assign mem_we   = !empty && !mem_busy && !reset;
  assign pop      = mem_we;

  always_comb begin
    newEntry       = '0;
    newEntry.waddr = 30'(st_addr[ADDR_W-1:2]);
    newEntry.strb  = encStrb;
    newEntry.wdata = encWdata;
  end

  always_comb begin
    headPtr_d     = headPtr_q;
    tailPtr_d     = tailPtr_q;
    count_d       = count_q;
    misalignErr_d = accept && encErr;
    if (pop)  headPtr_d = headPtr_q + PW'(1);
    if (push) tailPtr_d = tailPtr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      headPtr_q     <= '0;
      tailPtr_q     <= '0;
      count_q       <= '0;
      misalignErr_q <= 1'b0;
    end else begin
      headPtr_q     <= headPtr_d;
      tailPtr_q     <= tailPtr_d;
      count_q       <= count_d;
      misalignErr_q <= misalignErr_d;
    end
  end

  // Entry storage needs no reset: validity is derived from count/pointers.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      fifo_q[tailPtr_q] <= newEntry;
    end
  end

  always_comb begin
    headEntry = fifo_q[headPtr_q];
    mem_addr  = empty ? '0 : ADDR_W'({headEntry.waddr, 2'b00});
    mem_strb  = mem_we ? headEntry.strb : 4'b0000;
    mem_wdata = empty ? '0 : DATA_W'(headEntry.wdata);
  end

  // Slot i is live when its distance from the head is below the occupancy.
  // The head counts even while it drains; the incoming store never does.
  always_comb begin
    anyHit = 1'b0;
    offset = '0;
    ldWord = 30'(ld_addr[ADDR_W-1:2]);
    for (int i = 0; i < DEPTH; i++) begin
      offset = PW'(i) - headPtr_q;
      if ((CW'(offset) < count_q) && (fifo_q[i].waddr == ldWord)) begin
        anyHit = 1'b1;
      end
    end
    ld_hit = ld_valid && anyHit;
  end

  assign count        = count_q;
  assign misalign_err = misalignErr_q;

endmodule
